mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: turns execute-stage load/store ops into a single-beat
// memory request, aligns and extends load data, and reports a one-cycle writeback.
module mem_stage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_is_load,
  input  logic                    in_is_store,
  input  logic [1:0]              in_size,
  input  logic                    in_unsigned,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [4:0]              in_rd,
  input  logic [DATA_WIDTH-1:0]   in_alu_result,
  input  logic                    in_flush,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
  output logic                    out_valid,
  output logic [4:0]              out_rd,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_exc
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned LW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_MISALGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL = 2'd3;

  logic [1:0]            r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [4:0]            r_rd;
  logic                  r_killed;
  logic [7:0]            r_cnt;
  logic [4:0]            r_out_rd;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [1:0]            r_out_exc;

  logic                  w_is_mem;
  logic                  w_illegal;
  logic                  w_misal;
  logic [LW-1:0]         w_off;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_size_mask;
  logic                  w_sign;
  logic [DATA_WIDTH-1:0] w_load;
  logic [NB-1:0]         w_strb;
  logic                  w_kill_now;

  assign w_is_mem  = in_is_load | in_is_store;
  assign w_illegal = (in_is_load & in_is_store) | ((in_size == 2'd3) && (DATA_WIDTH == 32));
  assign w_off     = r_addr[LW-1:0];

  always_comb begin
    w_misal = 1'b0;
    case (in_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = in_addr[0];
      2'd2:    w_misal = |in_addr[1:0];
      default: w_misal = |in_addr[2:0];
    endcase
  end

  // Size mask is shared by load truncation and store data masking.
  always_comb begin
    w_size_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      w_size_mask[i] = (i < (32'd8 << r_size));
    w_shift = mem_resp_rdata >> {w_off, 3'b000};
    w_sign  = 1'b0;
    case (r_size)
      2'd0:    w_sign = w_shift[7];
      2'd1:    w_sign = w_shift[15];
      2'd2:    w_sign = w_shift[31];
      default: w_sign = w_shift[DATA_WIDTH-1];
    endcase
    w_load = w_shift & w_size_mask;
    if (!r_unsigned && w_sign)
      w_load = w_load | ~w_size_mask;
  end

  always_comb begin
    w_strb = '0;
    for (int unsigned j = 0; j < NB; j++)
      w_strb[j] = r_we && (j >= 32'(w_off)) && (j < 32'(w_off) + (32'd1 << r_size));
  end

  assign in_ready      = (r_state == S_IDLE) && !in_flush;
  assign mem_req_valid = (r_state == S_REQ) && !in_flush;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = {r_addr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
  assign mem_req_wdata = (r_wdata & w_size_mask) << {w_off, 3'b000};
  assign mem_req_wstrb = w_strb;
  assign out_valid     = (r_state == S_DONE) && !in_flush;
  assign out_rd        = r_out_rd;
  assign out_data      = r_out_data;
  assign out_exc       = r_out_exc;

  assign w_kill_now = r_killed | in_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_killed   <= 1'b0;
      r_cnt      <= '0;
      r_out_rd   <= '0;
      r_out_data <= '0;
      r_out_exc  <= EXC_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !in_flush) begin
            r_killed   <= 1'b0;
            r_out_rd   <= in_rd;
            r_out_data <= '0;
            r_out_exc  <= EXC_NONE;
            if (!w_is_mem) begin
              r_out_data <= in_alu_result;
              r_state    <= S_DONE;
            end else if (w_illegal) begin
              r_out_exc <= EXC_ILLEGAL;
              r_state   <= S_DONE;
            end else if (w_misal) begin
              r_out_exc <= EXC_MISALGN;
              r_state   <= S_DONE;
            end else begin
              r_we       <= in_is_store;
              r_size     <= in_size;
              r_unsigned <= in_unsigned;
              r_addr     <= in_addr;
              r_wdata    <= in_wdata;
              r_rd       <= in_rd;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (in_flush) begin
            r_state <= S_IDLE;
          end else if (mem_req_ready) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_flush)
            r_killed <= 1'b1;
          // A response in the last counted cycle wins over the timeout.
          if (mem_resp_valid) begin
            r_out_exc  <= EXC_NONE;
            r_out_data <= r_we ? '0 : w_load;
            r_out_rd   <= r_we ? 5'd0 : r_rd;
            r_state    <= w_kill_now ? S_IDLE : S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_out_exc  <= EXC_TIMEOUT;
            r_out_data <= '0;
            r_out_rd   <= r_we ? 5'd0 : r_rd;
            r_state    <= w_kill_now ? S_IDLE : S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model
// of address alignment, byte lanes, load extension, timeout and flush rules.
module tb_mem_stage;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_is_load, in_is_store, in_unsigned, in_flush;
  logic [1:0]    in_size;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata, in_alu_result;
  logic [4:0]    in_rd;
  logic          mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_rdata;
  logic [7:0]    mem_req_wstrb;
  logic          out_valid;
  logic [4:0]    out_rd;
  logic [DW-1:0] out_data;
  logic [1:0]    out_exc;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_flush(in_flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data), .out_exc(out_exc)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Current transaction
  logic        t_load, t_store, t_uns;
  logic [1:0]  t_size;
  logic [63:0] t_addr, t_wdata, t_alu, t_rdata;
  logic [4:0]  t_rd;

  function automatic logic [63:0] size_mask(input int unsigned size);
    return (size == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << size)) - 64'd1);
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input int unsigned size, input logic uns);
    logic [63:0] v;
    v = (rdata >> (8 * (addr % 8))) & size_mask(size);
    if (!uns && v[(8 << size) - 1]) v = v | ~size_mask(size);
    return v;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [63:0] addr, input int unsigned size);
    int unsigned bytes;
    bytes = 1 << size;
    return 8'(((1 << bytes) - 1) << (addr % 8));
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (strb[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] alu, input logic [63:0] rdata);
    t_load = ld; t_store = st; t_size = sz; t_uns = uns; t_addr = addr;
    t_wdata = wd; t_rd = rd; t_alu = alu; t_rdata = rdata;
  endtask

  task automatic accept();
    @(posedge clk); #1;
    in_valid = 1'b1; in_is_load = t_load; in_is_store = t_store; in_size = t_size;
    in_unsigned = t_uns; in_addr = t_addr; in_wdata = t_wdata; in_rd = t_rd;
    in_alu_result = t_alu;
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_req();
    logic [7:0] es;
    es = t_store ? exp_strb(t_addr, t_size) : 8'h00;
    chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("req_we", {63'd0, mem_req_we}, {63'd0, t_store});
    chk("req_addr", mem_req_addr, t_addr & ~64'h7);
    chk("req_wstrb", {56'd0, mem_req_wstrb}, {56'd0, es});
    if (t_store)
      chk("req_wdata", mem_req_wdata & lane_mask(es),
          (t_wdata & size_mask(t_size)) << (8 * (t_addr % 8)));
  endtask

  // fmode: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in DONE
  task automatic run_op(input int unsigned stall, input int unsigned lat, input int unsigned fmode);
    logic [1:0] ee;
    bit         mem_op, timed_out;
    mem_op = t_load || t_store;
    ee = 2'd0;
    if (mem_op && t_load && t_store) ee = 2'd3;
    else if (mem_op && (t_addr % (64'd1 << t_size)) != 0) ee = 2'd1;
    accept();
    if (!mem_op || ee != 0) begin
      if (fmode == 3) in_flush = 1'b1;
      @(negedge clk);
      chk("no_req", {63'd0, mem_req_valid}, 64'd0);
      chk("ov_direct", {63'd0, out_valid}, {63'd0, fmode != 3});
      if (fmode != 3) begin
        chk("exc_direct", {62'd0, out_exc}, {62'd0, ee});
        if (!mem_op) begin
          chk("pass_data", out_data, t_alu);
          chk("pass_rd", {59'd0, out_rd}, {59'd0, t_rd});
        end
      end
      @(posedge clk); #1; in_flush = 1'b0;
      @(negedge clk);
      chk("ov_pulse", {63'd0, out_valid}, 64'd0);
      return;
    end
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clk); check_req();
      @(posedge clk); #1;
    end
    if (fmode == 1) begin
      in_flush = 1'b1; mem_req_ready = 1'b1;
      @(negedge clk);
      chk("flush_req_valid", {63'd0, mem_req_valid}, 64'd0);
      @(posedge clk); #1; in_flush = 1'b0; mem_req_ready = 1'b0;
      @(negedge clk);
      chk("flush_req_idle", {63'd0, in_ready}, 64'd1);
      chk("flush_req_ov", {63'd0, out_valid}, 64'd0);
      return;
    end
    mem_req_ready = 1'b1;
    @(negedge clk); check_req();
    @(posedge clk); #1; mem_req_ready = 1'b0;
    if (fmode == 2) in_flush = 1'b1;
    timed_out = (lat >= TO);
    for (int c = 0; c < int'(TO); c++) begin
      if (c == int'(lat)) begin mem_resp_valid = 1'b1; mem_resp_rdata = t_rdata; end
      @(negedge clk);
      chk("wait_quiet", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1; mem_resp_valid = 1'b0; in_flush = 1'b0;
      if (c == int'(lat)) break;
    end
    if (fmode == 2) begin
      @(negedge clk); chk("killed_ov0", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("killed_ov1", {63'd0, out_valid}, 64'd0);
      chk("killed_idle", {63'd0, in_ready}, 64'd1);
      return;
    end
    if (fmode == 3) in_flush = 1'b1;
    @(negedge clk);
    chk("ov_mem", {63'd0, out_valid}, {63'd0, fmode != 3});
    if (fmode != 3) begin
      chk("exc_mem", {62'd0, out_exc}, timed_out ? 64'd2 : 64'd0);
      if (timed_out) chk("timeout_data", out_data, 64'd0);
      else if (t_load) begin
        chk("load_data", out_data, exp_load(t_rdata, t_addr, t_size, t_uns));
        chk("load_rd", {59'd0, out_rd}, {59'd0, t_rd});
      end else chk("store_rd", {59'd0, out_rd}, 64'd0);
    end
    @(posedge clk); #1; in_flush = 1'b0;
    @(negedge clk);
    chk("ov_pulse_mem", {63'd0, out_valid}, 64'd0);
    if (timed_out) begin
      mem_resp_valid = 1'b1; mem_resp_rdata = t_rdata;
      @(posedge clk); #1; mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("late_resp_ignored", {63'd0, out_valid}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_size = '0;
    in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_rd = '0; in_alu_result = '0;
    in_flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #3;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_exc", {62'd0, out_exc}, 64'd0);
    chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    set_op(0, 0, 2'd0, 0, 64'd0, 64'd0, 5'd5, 64'h1234, 64'd0);
    run_op(0, 0, 0);
    set_op(1, 0, 2'd0, 0, 64'h1003, 64'd0, 5'd7, 64'd0, 64'h0000_0000_8000_0000);
    run_op(0, 2, 0);
    chk("signed_byte_const", out_data, 64'hFFFF_FFFF_FFFF_FF80);
    set_op(1, 0, 2'd0, 1, 64'h1003, 64'd0, 5'd7, 64'd0, 64'h0000_0000_8000_0000);
    run_op(1, 1, 0);
    chk("unsigned_byte_const", out_data, 64'h80);
    set_op(0, 1, 2'd1, 0, 64'h1006, 64'hBEEF, 5'd9, 64'd0, 64'd0);
    run_op(1, 0, 0);
    set_op(1, 0, 2'd2, 0, 64'h1002, 64'd0, 5'd3, 64'd0, 64'd0);
    run_op(0, 0, 0);
    set_op(1, 0, 2'd3, 0, 64'h2000, 64'd0, 5'd4, 64'd0, 64'h1122_3344_5566_7788);
    run_op(3, TO + 4, 0);
    set_op(1, 0, 2'd2, 0, 64'h2004, 64'd0, 5'd6, 64'd0, 64'h8765_4321_0000_0000);
    run_op(0, TO - 1, 0);
    set_op(0, 1, 2'd2, 0, 64'h2004, 64'hCAFE_F00D, 5'd6, 64'd0, 64'd0);
    run_op(0, TO, 0);
    set_op(1, 0, 2'd1, 0, 64'h3002, 64'd0, 5'd8, 64'd0, 64'hFFFF_0000_1234_5678);
    run_op(0, 3, 2);
    set_op(1, 1, 2'd0, 0, 64'h3000, 64'd0, 5'd8, 64'd0, 64'd0);
    run_op(0, 0, 0);

    // Reset in REQ drops the request at once; a post-reset response is ignored.
    set_op(1, 0, 2'd0, 0, 64'h4001, 64'd0, 5'd2, 64'd0, 64'hFF);
    accept();
    #1; rst = 1'b0; #1;
    chk("rst_req_drop", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFF;
    @(negedge clk); chk("post_rst_resp0", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1; mem_resp_valid = 1'b0;
    @(negedge clk); chk("post_rst_resp1", {63'd0, out_valid}, 64'd0);

    for (int n = 0; n < 150; n++) begin
      int unsigned kind, sz, fr, fm;
      logic [63:0] a;
      kind = $urandom_range(0, 9);
      sz = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      if (kind == 9 || $urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      fr = $urandom_range(0, 11);
      fm = (fr == 9) ? 1 : (fr == 10) ? 2 : (fr == 11) ? 3 : 0;
      set_op(kind >= 2 && (kind <= 5 || kind == 9), kind >= 6, 2'(sz), 1'($urandom_range(0, 1)),
             a, {$urandom, $urandom}, 5'($urandom_range(0, 31)), {$urandom, $urandom},
             {$urandom, $urandom});
      run_op($urandom_range(0, 3), $urandom_range(0, TO + 1), fm);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
